// File: rtl/piano_tone_gen.sv
// piano_tone_gen
//   Monophonic piano voice. Debounces up to 12 chromatic key switches,
//   plays the lowest pressed key as a square wave with a release tail,
//   and shows the note name on two multiplexed seven-segment digits.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   switch         raw key switches (1 = pressed), key i = semitone i from C
//   speaker        square-wave audio output
//   seven_segment  {g,f,e,d,c,b,a}, active-low
//   AN             digit enables, active-low
//   note_valid     high while a note sounds (PLAY or RELEASE)
//   note_idx       index of the sounding note
module piano_tone_gen #(
  parameter int unsigned NUM_KEYS        = 12,
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned OCTAVE          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RELEASE_CYCLES  = 25000000,
  parameter int unsigned REFRESH_CYCLES  = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] switch,
  output logic                speaker,
  output logic [6:0]          seven_segment,
  output logic [7:0]          AN,
  output logic                note_valid,
  output logic [3:0]          note_idx
);

  function automatic int unsigned half_period(input int unsigned freq_hz);
    return (CLK_HZ / (2 * freq_hz)) >> (OCTAVE - 4);
  endfunction

  // Padded to 16 entries so a 4-bit index is always in range.
  localparam int unsigned HALF [16] = '{
    half_period(262), half_period(277), half_period(294), half_period(311),
    half_period(330), half_period(349), half_period(370), half_period(392),
    half_period(415), half_period(440), half_period(466), half_period(494),
    half_period(494), half_period(494), half_period(494), half_period(494)
  };

  localparam int unsigned TW = $clog2(half_period(262) + 1);
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RW = (RELEASE_CYCLES > 1)  ? $clog2(RELEASE_CYCLES)  : 1;
  localparam int unsigned FW = (REFRESH_CYCLES > 1)  ? $clog2(REFRESH_CYCLES)  : 1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } state_t;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] db_key_q, db_key_d;
  logic [DW-1:0]       db_cnt_q [NUM_KEYS];
  logic [DW-1:0]       db_cnt_d [NUM_KEYS];

  state_t              state_q, state_d;
  logic [TW-1:0]       tone_cnt_q, tone_cnt_d;
  logic                speaker_q, speaker_d;
  logic [3:0]          note_idx_q, note_idx_d;
  logic [RW-1:0]       rel_cnt_q, rel_cnt_d;
  logic [FW-1:0]       refresh_cnt_q, refresh_cnt_d;
  logic                digit_q, digit_d;

  logic                pressed;
  logic                sel_found;
  logic [3:0]          sel;
  logic [3:0]          next_note;
  logic [TW-1:0]       reload_val;
  logic [6:0]          letter_seg;
  logic                is_sharp;

  // ---------------------------------------------------------------- input path
  always_comb begin
    db_key_d = db_key_q;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      db_cnt_d[k] = '0;
    end
    // Counter only runs while the synchronised level disagrees; any agreement clears it.
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (sync2_q[k] != db_key_q[k]) begin
        if (db_cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_key_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    pressed   = |db_key_q;
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (db_key_q[k] && !sel_found) begin
        sel       = 4'(k);
        sel_found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- tone FSM
  // Selection is live in IDLE/PLAY but frozen to the sounding note in RELEASE.
  always_comb begin
    next_note  = (state_q != RELEASE && pressed) ? sel : note_idx_q;
    reload_val = TW'(HALF[next_note] - 1);
  end

  always_comb begin
    state_d    = state_q;
    tone_cnt_d = tone_cnt_q;
    speaker_d  = speaker_q;
    note_idx_d = note_idx_q;
    rel_cnt_d  = rel_cnt_q;

    case (state_q)
      IDLE: begin
        speaker_d = 1'b0;
        if (pressed) begin
          state_d    = PLAY;
          tone_cnt_d = reload_val;
          note_idx_d = next_note;
        end
      end

      PLAY, RELEASE: begin
        // Note changes only at half-period boundaries, so no runt pulses.
        if (tone_cnt_q == '0) begin
          speaker_d  = ~speaker_q;
          tone_cnt_d = reload_val;
          note_idx_d = next_note;
        end else begin
          tone_cnt_d = tone_cnt_q - TW'(1);
        end

        if (state_q == PLAY) begin
          if (!pressed) begin
            if (RELEASE_CYCLES == 0) begin
              state_d   = IDLE;
              speaker_d = 1'b0;
            end else begin
              state_d   = RELEASE;
              rel_cnt_d = RW'(RELEASE_CYCLES - 1);
            end
          end
        end else begin
          if (pressed) begin
            state_d = PLAY;
          end else if (rel_cnt_q == '0) begin
            state_d   = IDLE;
            speaker_d = 1'b0;
          end else begin
            rel_cnt_d = rel_cnt_q - RW'(1);
          end
        end
      end

      default: begin
        state_d   = IDLE;
        speaker_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- display
  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    digit_d       = digit_q;
    if (state_q == IDLE) begin
      refresh_cnt_d = '0;
      digit_d       = 1'b0;
    end else if (refresh_cnt_q == FW'(REFRESH_CYCLES - 1)) begin
      refresh_cnt_d = '0;
      digit_d       = ~digit_q;
    end else begin
      refresh_cnt_d = refresh_cnt_q + FW'(1);
    end
  end

  always_comb begin
    // Sharps reuse the letter of the natural below them.
    case (note_idx_q)
      4'd0, 4'd1:  letter_seg = 7'h46;
      4'd2, 4'd3:  letter_seg = 7'h21;
      4'd4:        letter_seg = 7'h06;
      4'd5, 4'd6:  letter_seg = 7'h0E;
      4'd7, 4'd8:  letter_seg = 7'h42;
      4'd9, 4'd10: letter_seg = 7'h08;
      default:     letter_seg = 7'h03;
    endcase
    is_sharp = note_idx_q inside {4'd1, 4'd3, 4'd6, 4'd8, 4'd10};

    AN            = 8'hFF;
    seven_segment = 7'h7F;
    if (state_q != IDLE) begin
      if (!digit_q) begin
        AN            = 8'hFE;
        seven_segment = letter_seg;
      end else if (is_sharp) begin
        AN            = 8'hFD;
        seven_segment = 7'h3F;
      end
    end
  end

  assign speaker    = speaker_q;
  assign note_idx   = note_idx_q;
  assign note_valid = (state_q != IDLE);

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_key_q      <= '0;
      db_cnt_q      <= '{default: '0};
      state_q       <= IDLE;
      tone_cnt_q    <= '0;
      speaker_q     <= 1'b0;
      note_idx_q    <= '0;
      rel_cnt_q     <= '0;
      refresh_cnt_q <= '0;
      digit_q       <= 1'b0;
    end else begin
      sync1_q       <= switch;
      sync2_q       <= sync1_q;
      db_key_q      <= db_key_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      tone_cnt_q    <= tone_cnt_d;
      speaker_q     <= speaker_d;
      note_idx_q    <= note_idx_d;
      rel_cnt_q     <= rel_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_q       <= digit_d;
    end
  end

endmodule

// File: tb/tb_piano_tone_gen.sv
module tb_piano_tone_gen;

  localparam int unsigned CLK_HZ = 26200;
  localparam int unsigned DEB    = 4;
  localparam int unsigned REL    = 100;
  localparam int unsigned REF    = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [11:0] switch = '0;
  logic        speaker;
  logic [6:0]  seven_segment;
  logic [7:0]  AN;
  logic        note_valid;
  logic [3:0]  note_idx;

  piano_tone_gen #(
    .NUM_KEYS(12),
    .CLK_HZ(CLK_HZ),
    .OCTAVE(4),
    .DEBOUNCE_CYCLES(DEB),
    .RELEASE_CYCLES(REL),
    .REFRESH_CYCLES(REF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .switch(switch),
    .speaker(speaker),
    .seven_segment(seven_segment),
    .AN(AN),
    .note_valid(note_valid),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  int unsigned freq [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

  // Reference model: note half-period, display glyphs.
  function automatic int unsigned half(input int unsigned k);
    return CLK_HZ / (2 * freq[k]);
  endfunction

  function automatic logic [6:0] letter(input int unsigned k);
    case (k)
      0, 1:    return 7'h46;
      2, 3:    return 7'h21;
      4:       return 7'h06;
      5, 6:    return 7'h0E;
      7, 8:    return 7'h42;
      9, 10:   return 7'h08;
      default: return 7'h03;
    endcase
  endfunction

  function automatic bit sharp(input int unsigned k);
    return (k == 1) || (k == 3) || (k == 6) || (k == 8) || (k == 10);
  endfunction

  function automatic logic [14:0] disp(input int unsigned k, input int unsigned c, input bit nv);
    if (!nv) return {8'hFF, 7'h7F};
    if (((c / REF) % 2) == 0) return {8'hFE, letter(k)};
    if (sharp(k)) return {8'hFD, 7'h3F};
    return {8'hFF, 7'h7F};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_entry();
    int unsigned lat;
    lat = 0;
    while (note_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("press_latency", lat, DEB + 3);
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (note_valid !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("back_to_idle", note_valid, 0);
  endtask

  // Length in samples of the speaker level present at the current sample.
  task automatic run_len(output int unsigned n);
    logic lvl;
    lvl = speaker;
    n = 1;
    tick();
    while (speaker === lvl && n < 400) begin
      n++;
      tick();
    end
  endtask

  // Press key k alone, hold it for c_rel samples after entry, then check the
  // tone continuing through the release tail and the return to silence.
  task automatic play_note(input int unsigned k, input int unsigned c_rel);
    int unsigned h;
    bit nv;
    switch = '0;
    switch[k] = 1'b1;
    wait_entry();
    chk("note_idx", note_idx, k);
    h = half(k);
    for (int unsigned c = 0; c < c_rel + DEB + 3 + REL + 10; c++) begin
      nv = (c < c_rel + DEB + 3 + REL);
      chk("note_valid", note_valid, nv);
      chk("speaker", speaker, nv ? (c / h) % 2 : 0);
      chk("display", {AN, seven_segment}, disp(k, c, nv));
      if (c == c_rel) switch = '0;
      tick();
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned j;
    int unsigned len;

    // Reset held with switches toggling, then idle after release.
    rst_n = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      switch = 12'($urandom);
      tick();
      chk("reset_outputs", {speaker, note_valid, AN, seven_segment}, {1'b0, 1'b0, 8'hFF, 7'h7F});
    end
    chk("reset_note_idx", note_idx, 0);
    switch = '0;
    tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      chk("idle_outputs", {speaker, note_valid, AN, seven_segment}, {1'b0, 1'b0, 8'hFF, 7'h7F});
    end

    // Single C, then a short bounce that must never debounce.
    play_note(0, 120);
    len = $urandom_range(1, 3);
    switch[1] = 1'b1;
    repeat (len) tick();
    switch = '0;
    for (int unsigned i = 0; i < 20; i++) begin
      chk("glitch_silent", {note_valid, speaker}, 0);
      tick();
    end

    // Sharp display, plus a few random keys.
    play_note(1, $urandom_range(20, 60));
    repeat (3) play_note($urandom_range(0, 11), $urandom_range(10, 150));

    // Two keys: lowest wins; dropping it switches at the next boundary.
    j = $urandom_range(1, 11);
    switch = '0;
    switch[0] = 1'b1;
    switch[j] = 1'b1;
    wait_entry();
    chk("prio_idx", note_idx, 0);
    chk("entry_low", speaker, 0);
    run_len(n); chk("prio_run0", n, half(0));
    switch = '0;
    switch[j] = 1'b1;
    run_len(n); chk("prio_run1_old", n, half(0));
    chk("prio_idx_new", note_idx, j);
    run_len(n); chk("prio_run2_new", n, half(j));
    run_len(n); chk("prio_run3_new", n, half(j));
    switch = '0;
    wait_idle();

    // Re-press during the release tail.
    switch = '0;
    switch[9] = 1'b1;
    wait_entry();
    run_len(n); chk("a_run0", n, half(9));
    run_len(n); chk("a_run1", n, half(9));
    switch = '0;
    run_len(n); chk("tail_run", n, half(9));
    chk("tail_valid", note_valid, 1);
    switch[4] = 1'b1;
    run_len(n); chk("tail_run_old", n, half(9));
    chk("repress_idx", note_idx, 4);
    run_len(n); chk("repress_run0", n, half(4));
    run_len(n); chk("repress_run1", n, half(4));
    chk("repress_valid", note_valid, 1);
    switch = '0;
    wait_idle();

    // Asynchronous reset mid half-period.
    switch = '0;
    switch[1] = 1'b1;
    wait_entry();
    repeat (half(1) + 10) tick();
    chk("pre_reset_speaker", speaker, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {speaker, note_valid, AN, seven_segment}, {1'b0, 1'b0, 8'hFF, 7'h7F});
    tick();
    tick();
    rst_n = 1'b1;
    wait_entry();
    chk("post_reset_idx", note_idx, 1);
    switch = '0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
